vga_timing_monitor: RTL

//  Receive side of the VGA timing interface: samples HSYNC/VSYNC/BLANK_N driven by a VGA timing

---
 rtl/vga_timing_monitor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_monitor.sv
// VGA timing monitor: measures line/frame length of an incoming raster, locks onto it and
// recovers pixel coordinates. Optional error counter enabled by defining VGA_MON_STATS_EN.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2,
  parameter int WDOG_CYCLES = 1600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] err_count,
  output logic [1:0]  fsm_state
);

  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state, state_next;

  logic            hs_d, vs_d, blank_d;
  logic [9:0]      h_cnt, v_cnt;
  logic [WD_W-1:0] wd_cnt, wd_next;
  logic [3:0]      good, good_next, good_inc;
  logic            h_seen, v_seen, frame_err;

  logic hs_fall, vs_fall, blank_rise, blank_fall;
  logic h_mis, v_mis, h_bad, v_bad;
  logic wdog_hit, clean, enter_search;

  // Handshake-free sampled interface: every input is taken as-is on each clock edge; there
  // is no valid/ready, the timing source owns the raster and this block only observes it.
  always_comb begin
    hs_fall    = hs_d & ~vga_hs;
    vs_fall    = vs_d & ~vga_vs;
    blank_rise = ~blank_d & vga_blank_n;
    blank_fall = blank_d & ~vga_blank_n;

    // A saturated line counter never matches, whatever H_TOTAL is.
    h_mis = (({1'b0, h_cnt} + 11'd1) != 11'(H_TOTAL)) || (h_cnt == 10'h3FF);
    v_mis = (({1'b0, v_cnt} + 11'd1) != 11'(V_TOTAL));
    h_bad = hs_fall & h_seen & h_mis;
    v_bad = vs_fall & v_seen & v_mis;

    if (hs_fall)
      wd_next = '0;
    else if (wd_cnt == WD_W'(WDOG_CYCLES))
      wd_next = wd_cnt;
    else
      wd_next = wd_cnt + 1'b1;
    wdog_hit = (wd_next == WD_W'(WDOG_CYCLES));

    clean    = ~v_bad & ~frame_err & ~h_bad;
    good_inc = good + 4'd1;
  end

  always_comb begin
    state_next = state;
    good_next  = good;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_next = ACQUIRE;
          good_next  = '0;
        end
      end
      ACQUIRE: begin
        if (vs_fall) begin
          if (clean) begin
            good_next = good_inc;
            if (good_inc >= 4'(LOCK_FRAMES))
              state_next = LOCKED;
          end else begin
            good_next = '0;
          end
        end
      end
      LOCKED: begin
        if (h_bad || v_bad)
          state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
    if (wdog_hit) begin
      state_next = SEARCH;
      good_next  = '0;
    end
    // Only the transition into SEARCH forgets history, so errors keep being measured there.
    enter_search = wdog_hit || ((state != SEARCH) && (state_next == SEARCH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
      good  <= '0;
    end else begin
      state <= state_next;
      good  <= good_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      blank_d     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      wd_cnt      <= '0;
      h_seen      <= 1'b0;
      v_seen      <= 1'b0;
      frame_err   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      hs_d    <= vga_hs;
      vs_d    <= vga_vs;
      blank_d <= vga_blank_n;
      wd_cnt  <= wd_next;

      if (hs_fall)
        h_cnt <= '0;
      else if (h_cnt != 10'h3FF)
        h_cnt <= h_cnt + 10'd1;

      if (vs_fall)
        v_cnt <= '0;
      else if (hs_fall)
        v_cnt <= v_cnt + 10'd1;

      if (enter_search)
        h_seen <= 1'b0;
      else if (hs_fall)
        h_seen <= 1'b1;

      if (enter_search)
        v_seen <= 1'b0;
      else if (vs_fall)
        v_seen <= 1'b1;

      if (vs_fall)
        frame_err <= 1'b0;
      else if (h_bad)
        frame_err <= 1'b1;

      if (blank_rise)
        pix_x <= '0;
      else if (vga_blank_n)
        pix_x <= pix_x + 10'd1;

      if (vs_fall)
        pix_y <= '0;
      else if (blank_fall)
        pix_y <= pix_y + 10'd1;

      pix_valid   <= vga_blank_n & (state == LOCKED);
      frame_start <= vs_fall;
      h_err       <= h_bad;
      v_err       <= v_bad;
    end
  end

  assign locked    = (state == LOCKED);
  assign fsm_state = state;

`ifdef VGA_MON_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      err_count <= '0;
    else if ((h_bad || v_bad) && (err_count != 16'hFFFF))
      err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule
